// File: rtl/grid_ctrl_axil_slave_regs.sv
// AXI4-Lite responder register file for the grid controller.
// Independent single-outstanding write and read paths; out-of-range word offsets answer SLVERR.
module grid_ctrl_axil_slave_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned NUM_REGS           = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_q,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned STRB_W = DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_WAIT   = 2'd1;
    localparam logic [1:0] W_COMMIT = 2'd2;
    localparam logic [1:0] W_RESP   = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [DW-1:0] reg_file [NUM_REGS];

    // Write path state
    logic [1:0]        w_state, w_state_nxt;
    logic              aw_held, aw_held_nxt;
    logic              w_held, w_held_nxt;
    logic [IDX_W-1:0]  aw_idx, aw_idx_nxt;
    logic [DW-1:0]     w_data, w_data_nxt;
    logic [STRB_W-1:0] w_strb, w_strb_nxt;
    logic              awready_nxt, wready_nxt, bvalid_nxt;
    logic [1:0]        bresp_nxt;
    logic              aw_hs_c, w_hs_c, commit_c, aw_in_range_c;

    // Read path state
    logic [0:0]        r_state, r_state_nxt;
    logic              arready_nxt, rvalid_nxt;
    logic [DW-1:0]     rdata_nxt;
    logic [1:0]        rresp_nxt;
    logic [IDX_W-1:0]  ar_idx_c;
    logic [DW-1:0]     rd_word_c;
    logic              ar_hs_c, ar_in_range_c;

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs_c       = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs_c        = S_AXI_WVALID && S_AXI_WREADY;
    assign aw_in_range_c = (32'(aw_idx) < NUM_REGS);

    // Write next-state: AW and W are latched independently, commit once both are held
    always_comb begin
        w_state_nxt = w_state;
        aw_held_nxt = aw_held || aw_hs_c;
        w_held_nxt  = w_held || w_hs_c;
        aw_idx_nxt  = aw_hs_c ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx;
        w_data_nxt  = w_hs_c ? S_AXI_WDATA : w_data;
        w_strb_nxt  = w_hs_c ? S_AXI_WSTRB : w_strb;
        bvalid_nxt  = S_AXI_BVALID;
        bresp_nxt   = S_AXI_BRESP;
        commit_c    = 1'b0;
        case (w_state)
            W_IDLE, W_WAIT: begin
                if (aw_held_nxt && w_held_nxt) begin
                    w_state_nxt = W_COMMIT;
                end else if (aw_held_nxt || w_held_nxt) begin
                    w_state_nxt = W_WAIT;
                end
            end
            W_COMMIT: begin
                commit_c    = 1'b1;
                aw_held_nxt = 1'b0;
                w_held_nxt  = 1'b0;
                bvalid_nxt  = 1'b1;
                bresp_nxt   = aw_in_range_c ? RESP_OKAY : RESP_SLVERR;
                w_state_nxt = W_RESP;
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_nxt  = 1'b0;
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
        awready_nxt = !aw_held_nxt && !bvalid_nxt;
        wready_nxt  = !w_held_nxt && !bvalid_nxt;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
        end else begin
            w_state       <= w_state_nxt;
            aw_held       <= aw_held_nxt;
            w_held        <= w_held_nxt;
            aw_idx        <= aw_idx_nxt;
            w_data        <= w_data_nxt;
            w_strb        <= w_strb_nxt;
            S_AXI_AWREADY <= awready_nxt;
            S_AXI_WREADY  <= wready_nxt;
            S_AXI_BVALID  <= bvalid_nxt;
            S_AXI_BRESP   <= bresp_nxt;
        end
    end

    // Register file update; the strobe fires even when no byte lane is enabled
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                reg_file[k] <= '0;
            end
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (commit_c && aw_in_range_c) begin
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    if (32'(aw_idx) == k) begin
                        for (int unsigned b = 0; b < STRB_W; b++) begin
                            if (w_strb[b]) begin
                                reg_file[k][8*b +: 8] <= w_data[8*b +: 8];
                            end
                        end
                        reg_wr_pulse[k] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_q
        assign reg_q[DW*k +: DW] = reg_file[k];
    end

    assign ar_hs_c       = S_AXI_ARVALID && S_AXI_ARREADY;
    assign ar_idx_c      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_in_range_c = (32'(ar_idx_c) < NUM_REGS);

    always_comb begin
        rd_word_c = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (32'(ar_idx_c) == k) begin
                rd_word_c = reg_file[k];
            end
        end
    end

    // Read next-state: data is captured from the pre-edge register contents
    always_comb begin
        r_state_nxt = r_state;
        rvalid_nxt  = S_AXI_RVALID;
        rdata_nxt   = S_AXI_RDATA;
        rresp_nxt   = S_AXI_RRESP;
        case (r_state)
            R_IDLE: begin
                if (ar_hs_c) begin
                    r_state_nxt = R_DATA;
                    rvalid_nxt  = 1'b1;
                    rdata_nxt   = ar_in_range_c ? rd_word_c : '0;
                    rresp_nxt   = ar_in_range_c ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    r_state_nxt = R_IDLE;
                    rvalid_nxt  = 1'b0;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
        arready_nxt = (r_state_nxt == R_IDLE);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            r_state       <= r_state_nxt;
            S_AXI_ARREADY <= arready_nxt;
            S_AXI_RVALID  <= rvalid_nxt;
            S_AXI_RDATA   <= rdata_nxt;
            S_AXI_RRESP   <= rresp_nxt;
        end
    end

endmodule

// File: tb/tb_grid_ctrl_axil_slave_regs.sv
// Self-checking bench for grid_ctrl_axil_slave_regs: directed scenarios plus randomized
// traffic compared against an array-based register model.
module tb_grid_ctrl_axil_slave_regs;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   awaddr = '0;
    logic [2:0]      awprot = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b1;
    logic [AW-1:0]   araddr = '0;
    logic [2:0]      arprot = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b1;
    logic [DW*NR-1:0] reg_q;
    logic [NR-1:0]   reg_wr_pulse;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model [NR];

    grid_ctrl_axil_slave_regs #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR)
    ) dut (
        .S_AXI_ACLK(clk),       .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(awprot),  .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),    .S_AXI_WSTRB(wstrb),    .S_AXI_WVALID(wvalid),   .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),    .S_AXI_BVALID(bvalid),  .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),  .S_AXI_ARPROT(arprot),  .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),    .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready),
        .reg_q(reg_q),          .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [DW*NR-1:0] model_q();
        logic [DW*NR-1:0] v;
        for (int k = 0; k < NR; k++) v[DW*k +: DW] = model[k];
        return v;
    endfunction

    function automatic bit in_range(input logic [AW-1:0] a);
        return (int'(a) / 4) < NR;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a) / 4;
        if (idx >= NR) return;
        for (int b = 0; b < 4; b++)
            if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic logic [NR-1:0] model_pulse(input logic [AW-1:0] a);
        logic [NR-1:0] p;
        p = '0;
        if (in_range(a)) p[int'(a) / 4] = 1'b1;
        return p;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NR; k++) model[k] = '0;
    endfunction

    // ---------------- bus drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_aw_w(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        bit af, wf, ok;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            af = awvalid && awready;
            wf = wvalid && wready;
            tick();
            if (af) awvalid = 1'b0;
            if (wf) wvalid = 1'b0;
            if (!awvalid && !wvalid) begin ok = 1'b1; break; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL aw_w_handshake: timed out, required handshake within 50 cycles");
        end
    endtask

    task automatic wait_bvalid();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bvalid) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL bvalid_wait: timed out, required BVALID within 20 cycles");
        end
    endtask

    task automatic drive_ar(input logic [AW-1:0] a);
        bit ok, f;
        araddr = a; arvalid = 1'b1; ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            f = arready;
            tick();
            if (f) begin ok = 1'b1; break; end
        end
        arvalid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL ar_handshake: timed out, required handshake within 50 cycles");
        end
    endtask

    task automatic wait_rvalid();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (rvalid) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL rvalid_wait: timed out, required RVALID within 20 cycles");
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [NR-1:0] pulse);
        bready = 1'b1;
        drive_aw_w(a, d, s);
        wait_bvalid();
        resp = bresp;
        pulse = reg_wr_pulse;
        tick();
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        rready = 1'b1;
        drive_ar(a);
        wait_rvalid();
        d = rdata;
        resp = rresp;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_handshake: got %b required 00000", {awready, wready, arready, bvalid, rvalid});
        end
        vectors++;
        if ({bresp, rresp, rdata, reg_wr_pulse} !== '0) begin
            miscompares++;
            $display("FAIL reset_resp_data: got bresp=%b rresp=%b rdata=%h pulse=%b required all 0", bresp, rresp, rdata, reg_wr_pulse);
        end
        vectors++;
        if (reg_q !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: got %h required 0", reg_q);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({awready, wready, arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic_rw();
        logic [1:0] resp;
        logic [NR-1:0] pulse;
        logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            axi_write(AW'(4 * k), 32'(k + 1), 4'hF, resp, pulse);
            model_write(AW'(4 * k), 32'(k + 1), 4'hF);
            vectors++;
            if (resp !== 2'b00 || pulse !== model_pulse(AW'(4 * k))) begin
                miscompares++;
                $display("FAIL basic_write[%0d]: got bresp=%b pulse=%b required 00/%b", k, resp, pulse, model_pulse(AW'(4 * k)));
            end
        end
        for (int k = 0; k < 4; k++) begin
            axi_read(AW'(4 * k), d, resp);
            vectors++;
            if (d !== 32'(k + 1) || resp !== 2'b00) begin
                miscompares++;
                $display("FAIL basic_read[%0d]: got %h/%b required %h/00", k, d, resp, 32'(k + 1));
            end
        end
    endtask

    task automatic test_latency();
        awaddr = AW'(8); wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(AW'(8), 32'h0BAD_F00D, 4'hF);
        vectors++;
        if ({awready, wready, bvalid} !== 3'b000) begin
            miscompares++;
            $display("FAIL latency_n1: got awready/wready/bvalid=%b required 000", {awready, wready, bvalid});
        end
        tick();
        vectors++;
        if (bvalid !== 1'b1 || reg_wr_pulse !== 4'b0100 || reg_q !== model_q()) begin
            miscompares++;
            $display("FAIL latency_n2: got bvalid=%b pulse=%b q=%h required 1/0100/%h", bvalid, reg_wr_pulse, reg_q, model_q());
        end
        tick();
    endtask

    task automatic test_w_before_aw();
        bit w_done, aw_done, wf, af;
        int nb, np1, npo;
        logic [1:0] resp;
        w_done = 0; aw_done = 0; nb = 0; np1 = 0; npo = 0; resp = 2'b11;
        awaddr = AW'(4); wdata = 32'hDEAD_BEEF; wstrb = 4'hF; bready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            wvalid = !w_done;
            awvalid = (c >= 3) && !aw_done;
            wf = wvalid && wready;
            af = awvalid && awready;
            tick();
            if (wf) w_done = 1;
            if (af) aw_done = 1;
            if (bvalid) begin nb++; resp = bresp; end
            if (reg_wr_pulse[1]) np1++;
            if (reg_wr_pulse[0] || reg_wr_pulse[2] || reg_wr_pulse[3]) npo++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(AW'(4), 32'hDEAD_BEEF, 4'hF);
        vectors++;
        if (nb !== 1 || resp !== 2'b00) begin
            miscompares++;
            $display("FAIL w_before_aw_bvalid: got %0d cycles resp=%b required 1/00", nb, resp);
        end
        vectors++;
        if (np1 !== 1 || npo !== 0) begin
            miscompares++;
            $display("FAIL w_before_aw_pulse: got pulse1=%0d other=%0d required 1/0", np1, npo);
        end
        vectors++;
        if (reg_q !== model_q()) begin
            miscompares++;
            $display("FAIL w_before_aw_regs: got %h required %h", reg_q, model_q());
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp;
        logic [NR-1:0] pulse;
        axi_write(AW'(8), 32'hFFFF_FFFF, 4'hF, resp, pulse);
        model_write(AW'(8), 32'hFFFF_FFFF, 4'hF);
        axi_write(AW'(8), 32'h1234_5678, 4'b0101, resp, pulse);
        model_write(AW'(8), 32'h1234_5678, 4'b0101);
        vectors++;
        if (reg_q[95:64] !== 32'hFF34_FF78 || reg_q !== model_q()) begin
            miscompares++;
            $display("FAIL strobe_merge: got %h required FF34FF78", reg_q[95:64]);
        end
        axi_write(AW'(8), 32'h0, 4'b0000, resp, pulse);
        vectors++;
        if (pulse !== 4'b0100 || reg_q !== model_q()) begin
            miscompares++;
            $display("FAIL strobe_zero: got pulse=%b q=%h required 0100/%h", pulse, reg_q, model_q());
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp;
        logic [NR-1:0] pulse;
        logic [31:0] d;
        axi_write(AW'(6'h10), 32'hCAFE_CAFE, 4'hF, resp, pulse);
        vectors++;
        if (resp !== 2'b10 || pulse !== 4'b0 || reg_q !== model_q()) begin
            miscompares++;
            $display("FAIL oor_write: got bresp=%b pulse=%b q=%h required 10/0000/%h", resp, pulse, reg_q, model_q());
        end
        axi_read(AW'(6'h3C), d, resp);
        vectors++;
        if (resp !== 2'b10 || d !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_read: got %h/%b required 00000000/10", d, resp);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] r0;
        logic [31:0] d0;
        bready = 1'b0;
        drive_aw_w(AW'(12), 32'h5555_AAAA, 4'hF);
        model_write(AW'(12), 32'h5555_AAAA, 4'hF);
        wait_bvalid();
        r0 = bresp;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (bvalid !== 1'b1 || bresp !== r0 || awready !== 1'b0 || wready !== 1'b0) begin
                miscompares++;
                $display("FAIL b_stall[%0d]: got bvalid=%b bresp=%b awr=%b wr=%b required 1/%b/0/0", c, bvalid, bresp, awready, wready, r0);
            end
        end
        bready = 1'b1;
        tick();
        vectors++;
        if (bvalid !== 1'b0 || r0 !== 2'b00) begin
            miscompares++;
            $display("FAIL b_release: got bvalid=%b resp=%b required 0/00", bvalid, r0);
        end
        rready = 1'b0;
        drive_ar(AW'(12));
        wait_rvalid();
        d0 = rdata;
        arvalid = 1'b1; araddr = AW'(0);
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (rvalid !== 1'b1 || rdata !== model[3] || rresp !== 2'b00 || arready !== 1'b0) begin
                miscompares++;
                $display("FAIL r_stall[%0d]: got rvalid=%b rdata=%h rresp=%b arr=%b required 1/%h/00/0", c, rvalid, rdata, rresp, arready, model[3]);
            end
        end
        arvalid = 1'b0;
        rready = 1'b1;
        tick();
        vectors++;
        if (rvalid !== 1'b0 || arready !== 1'b1 || d0 !== model[3]) begin
            miscompares++;
            $display("FAIL r_release: got rvalid=%b arready=%b data=%h required 0/1/%h", rvalid, arready, d0, model[3]);
        end
    endtask

    task automatic test_back_to_back();
        int nhs, nb;
        logic [3:0] idx;
        bit f;
        nhs = 0; nb = 0;
        bready = 1'b1;
        idx = 4'($urandom_range(0, NR - 1));
        awaddr = {idx, 2'b00}; wdata = $urandom; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            f = awready && wready;
            tick();
            if (bvalid) nb++;
            if (f) begin
                nhs++;
                model_write(awaddr, wdata, wstrb);
                idx = 4'($urandom_range(0, NR - 1));
                awaddr = {idx, 2'b00};
                wdata = $urandom;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (3) tick();
        vectors++;
        if (nhs !== 10 || nb !== 10) begin
            miscompares++;
            $display("FAIL b2b_rate: got %0d writes %0d responses in 30 cycles required 10/10", nhs, nb);
        end
        vectors++;
        if (reg_q !== model_q()) begin
            miscompares++;
            $display("FAIL b2b_regs: got %h required %h", reg_q, model_q());
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] resp;
        logic [NR-1:0] pulse;
        logic [31:0] d;
        bready = 1'b0;
        drive_aw_w(AW'(0), 32'h0000_00A5, 4'hF);
        wait_bvalid();
        vectors++;
        if (reg_q[31:0] !== 32'hA5) begin
            miscompares++;
            $display("FAIL areset_pre: got reg0=%h required 000000a5", reg_q[31:0]);
        end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b0 || reg_q !== '0) begin
            miscompares++;
            $display("FAIL areset_async: got bvalid=%b rvalid=%b awr=%b q=%h required 0/0/0/0", bvalid, rvalid, awready, reg_q);
        end
        bready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        vectors++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_release: got bvalid=%b rvalid=%b awr=%b required 0/0/1", bvalid, rvalid, awready);
        end
        axi_write(AW'(0), 32'h0000_0077, 4'hF, resp, pulse);
        model_write(AW'(0), 32'h0000_0077, 4'hF);
        axi_read(AW'(0), d, resp);
        vectors++;
        if (d !== model[0] || resp !== 2'b00) begin
            miscompares++;
            $display("FAIL areset_after: got %h/%b required %h/00", d, resp, model[0]);
        end
    endtask

    task automatic test_random();
        logic [1:0] resp, er;
        logic [NR-1:0] pulse;
        logic [31:0] d, ed, wd;
        logic [3:0] idx, st;
        logic [1:0] lo;
        logic [AW-1:0] a;
        for (int n = 0; n < 60; n++) begin
            idx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(NR, 15)) : 4'($urandom_range(0, NR - 1));
            lo = 2'($urandom);
            a = {idx, lo};
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom;
                st = 4'($urandom);
                axi_write(a, wd, st, resp, pulse);
                model_write(a, wd, st);
                er = in_range(a) ? 2'b00 : 2'b10;
                vectors++;
                if (resp !== er || pulse !== model_pulse(a) || reg_q !== model_q()) begin
                    miscompares++;
                    $display("FAIL rand_write[%0d] a=%h: got %b/%b/%h required %b/%b/%h", n, a, resp, pulse, reg_q, er, model_pulse(a), model_q());
                end
            end else begin
                axi_read(a, d, resp);
                ed = in_range(a) ? model[int'(a) / 4] : 32'h0;
                er = in_range(a) ? 2'b00 : 2'b10;
                vectors++;
                if (d !== ed || resp !== er) begin
                    miscompares++;
                    $display("FAIL rand_read[%0d] a=%h: got %h/%b required %h/%b", n, a, d, resp, ed, er);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_rw();
        test_latency();
        test_w_before_aw();
        test_strobe();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
